// File: rtl/mux_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for mux_share_arb.
package mux_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 2;
    localparam int BURST_DEF = 4;
    localparam int MAX_REQ   = 8;

    // Returns {found, index} of the first set request in the order
    // last+1, last+2, ... wrapping modulo n. The request vector is
    // zero-extended to MAX_REQ bits by the caller.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [3:0] r;
        int         idx;
        r = '0;
        // Walk from the farthest candidate to the nearest so the nearest
        // requesting index is the one that sticks.
        for (int i = MAX_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % n;
            if (i <= n && req[idx[2:0]]) r = {1'b1, idx[2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_w.sv
// N_REQ:1 combinational mux, W bits wide, steered by sel_i.
module muxn_w #(
    parameter int N_REQ = 4,
    parameter int W     = 2,
    parameter int SW    = $clog2(N_REQ)
) (
    input  logic [N_REQ*W-1:0] d_i,
    input  logic [SW-1:0]      sel_i,
    output logic [W-1:0]       y_o
);

    // Select requester slice sel_i; out-of-range selects read as zero.
    always_comb begin
        y_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_i == SW'(i)) y_o = d_i[i*W +: W];
        end
    end

endmodule

// File: rtl/mux_share_arb.sv
// Round-robin arbiter sharing one W-bit mux among N_REQ requesters.
// Grants one requester for up to BURST transfers, then bubbles one IDLE cycle.
// Optional macro ARB_LOCK_EN adds a lock port that extends a burst.
module mux_share_arb
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       d,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]         lock,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic [W-1:0]             y,
    output logic                     y_valid
);

    localparam int SW = $clog2(N_REQ);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_e     state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [SW-1:0]  last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   y_q, y_d;
    logic           vld_q, vld_d;

    logic [W-1:0]   mux_y;
    logic [7:0]     req8;
    logic [3:0]     pick;
    logic           lock_hit;

    muxn_w #(.N_REQ(N_REQ), .W(W), .SW(SW)) u_mux (
        .d_i   (d),
        .sel_i (sel_q),
        .y_o   (mux_y)
    );

    // Round-robin candidate from the registered pointer.
    always_comb begin
        req8 = '0;
        req8[N_REQ-1:0] = req;
        pick = rr_pick(req8, 3'(last_q), N_REQ);
    end

`ifdef ARB_LOCK_EN
    assign lock_hit = lock[sel_q];
`else
    assign lock_hit = 1'b0;
`endif

    // Next-state and output decode for the IDLE/BUSY sequencer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick[3]) begin
                    gnt_d   = N_REQ'(1) << pick[2:0];
                    sel_d   = SW'(pick[2:0]);
                    cnt_d   = CW'(BURST - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    // Requester let go early: no transfer this edge.
                    gnt_d   = '0;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else begin
                    y_d   = mux_y;
                    vld_d = 1'b1;
                    if (cnt_q == '0) begin
                        if (lock_hit) begin
                            // Locked: keep the grant and the pointer.
                            cnt_d = CW'(BURST - 1);
                        end else begin
                            gnt_d   = '0;
                            last_d  = sel_q;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; pointer starts at N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SW'(N_REQ - 1);
            cnt_q   <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = vld_q;

endmodule

// File: tb/tb_mux_share_arb.sv
// Directed bench for mux_share_arb (N_REQ=4, W=2, BURST=4).
module tb_mux_share_arb;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] d;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] y;
    logic       y_valid;

    int n_chk  = 0;
    int n_pass = 0;

    mux_share_arb #(.N_REQ(4), .W(2), .BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .d       (d),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] d;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [1:0] y;
        logic       yv;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] dd,
                       input logic [3:0] g, input logic [1:0] s,
                       input logic [1:0] yy, input logic v);
        vec_t e;
        e.rst = r; e.req = rq; e.d = dd; e.gnt = g; e.sel = s; e.y = yy; e.yv = v;
        vt.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_outs(input string name, input logic [3:0] g, input logic [1:0] s,
                              input logic [1:0] yy, input logic v);
        check(name, {23'd0, gnt, sel, y, y_valid}, {23'd0, g, s, yy, v});
    endtask

    initial begin
        int run;
        logic seen;
        logic [1:0] yprev;
        reset = 1'b1; req = '0; d = '0; lock = '0;
        #1;
        // Reset state, checked before any clock edge.
        check_outs("reset_state", 4'b0000, 2'd0, 2'd0, 1'b0);

        // Single requester, d[0]=10: grant, 4 transfers, release, bubble, regrant.
        add(1, 4'b0001, 8'h02, 4'b0000, 0, 2'b00, 0);
        add(0, 4'b0001, 8'h02, 4'b0001, 0, 2'b00, 0);
        add(0, 4'b0001, 8'h02, 4'b0001, 0, 2'b10, 1);
        add(0, 4'b0001, 8'h02, 4'b0001, 0, 2'b10, 1);
        add(0, 4'b0001, 8'h02, 4'b0001, 0, 2'b10, 1);
        add(0, 4'b0001, 8'h02, 4'b0000, 0, 2'b10, 1);
        add(0, 4'b0001, 8'h02, 4'b0001, 0, 2'b10, 0);
        add(0, 4'b0001, 8'h02, 4'b0001, 0, 2'b10, 1);
        add(0, 4'b0000, 8'h02, 4'b0000, 0, 2'b10, 0);
        add(0, 4'b0000, 8'h02, 4'b0000, 0, 2'b10, 0);

        // Early release: requester 2 drops after 2 transfers, 3 wins next.
        add(1, 4'b1100, 8'hE4, 4'b0000, 0, 2'b00, 0);
        add(0, 4'b1100, 8'hE4, 4'b0100, 2, 2'b00, 0);
        add(0, 4'b1100, 8'hE4, 4'b0100, 2, 2'b10, 1);
        add(0, 4'b1100, 8'hE4, 4'b0100, 2, 2'b10, 1);
        add(0, 4'b1000, 8'hE4, 4'b0000, 2, 2'b10, 0);
        add(0, 4'b1000, 8'hE4, 4'b1000, 3, 2'b10, 0);
        add(0, 4'b1000, 8'hE4, 4'b1000, 3, 2'b11, 1);

        // Round robin, all requesting, d[k]=k: order 0,1,2,3,0.
        add(1, 4'b1111, 8'hE4, 4'b0000, 0, 2'b00, 0);
        yprev = 2'b00;
        for (int g = 0; g < 5; g++) begin
            logic [1:0] k;
            k = 2'(g % 4);
            add(0, 4'b1111, 8'hE4, 4'b0001 << k, k, yprev, 0);
            for (int t = 0; t < 3; t++) add(0, 4'b1111, 8'hE4, 4'b0001 << k, k, k, 1);
            add(0, 4'b1111, 8'hE4, 4'b0000, k, k, 1);
            yprev = k;
        end

        foreach (vt[i]) begin
            reset = vt[i].rst; req = vt[i].req; d = vt[i].d;
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].sel, vt[i].y, vt[i].yv);
        end

        // Asynchronous reset in the middle of a burst to requester 1.
        reset = 1'b1; req = 4'b0010; d = 8'hE4;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_outs("mid_grant", 4'b0010, 2'd1, 2'b00, 1'b0);
        @(posedge clk); #1;
        check_outs("mid_xfer", 4'b0010, 2'd1, 2'b01, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_outs("async_rst", 4'b0000, 2'd0, 2'b00, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_outs("regrant", 4'b0010, 2'd1, 2'b00, 1'b0);

        // Lock run: requester 1 holds req (and lock until 8 transfers seen).
        reset = 1'b1; req = 4'b0010; lock = 4'b0010;
        @(posedge clk); #1;
        reset = 1'b0;
        run = 0; seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (y_valid) begin
                seen = 1'b1;
                run++;
                if (run == 8) lock = 4'b0000;
            end else if (seen) begin
                break;
            end
        end
`ifdef ARB_LOCK_EN
        check("lock_run", run, 12);
`else
        check("burst_run", run, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_share_arb.md
# mux_share_arb

Round-robin arbiter and sequencer that shares one W-bit output multiplexer among N_REQ requesters. Each requester raises `req[i]` and presents data on its slice of `d`. The block grants one requester at a time for a bounded burst, drives the internal mux select, and registers the selected data onto `y` with a `y_valid` qualifier. It sits in front of the lab's mux datapath and replaces the testbench-driven select with a clocked controller.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `W`, default 2: data width per requester.
- `BURST`, default 4: maximum transfers per grant; must be at least 1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  request per requester; level-sensitive.
- `d`  in  N_REQ*W  flattened data; requester i occupies `d[i*W +: W]`.
- `lock`  in  N_REQ  burst-extend request; port exists only with ARB_LOCK_EN.
- `gnt`  out  N_REQ  one-hot grant, registered; all zero when idle.
- `sel`  out  clog2(N_REQ)  current mux select, registered.
- `y`  out  W  registered mux output.
- `y_valid`  out  1  `y` holds a transfer from the granted requester.

## Operation
- Reset values:
  - state = IDLE.
  - `gnt` = 0, `sel` = 0, `y` = 0, `y_valid` = 0.
  - Round-robin pointer `last` = N_REQ-1, so requester 0 wins first.
  - Burst counter `cnt` = 0.
- Reset is asynchronous: asserting it mid-burst clears all state and outputs immediately. No partial burst resumes after release.
- IDLE state:
  - `y_valid` <= 0; `y` holds its last value.
  - If any `req` bit is high at the edge, grant the first requester set in the order last+1, last+2, … (wrapping modulo N_REQ).
  - On a grant: `gnt` <= onehot(k), `sel` <= k, `cnt` <= BURST-1, state <= BUSY.
- BUSY state, evaluated at each edge:
  - If `req[sel]` = 0, this is an early release:
    - `y_valid` <= 0.
    - `gnt` <= 0, `last` <= `sel`, state <= IDLE.
  - Otherwise, transfer:
    - `y` <= `d[sel]`, `y_valid` <= 1.
    - If `cnt` = 0, release: `gnt` <= 0, `last` <= `sel`, state <= IDLE.
    - Else `cnt` <= `cnt`-1.
- Requests from other requesters during BUSY are ignored; they are arbitrated at the next IDLE edge.
- `cnt` width is max(1, clog2(BURST)). `cnt` never wraps below zero.

## Timing
- Request to grant: `req[k]` high before edge n gives `gnt[k]` high after edge n.
- Grant to data: first `y_valid` appears after edge n+1. `y` lags `gnt` by one cycle.
- A full burst with `req` held gives:
  - `gnt` high for BURST cycles;
  - `y_valid` high for BURST consecutive cycles, offset by one.
- There is exactly one IDLE bubble cycle between consecutive grants.
- `y` changes only on transfer edges. Data on `d` is sampled at the edge, not forwarded combinationally.

## Configuration
- `ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - At a BUSY edge with `cnt` = 0, `req[sel]` = 1 and `lock[sel]` = 1, the transfer still occurs. In addition, `cnt` reloads to BURST-1, the grant holds, and `last` is not updated.
  - Early release on `req` drop still applies.
- `ARB_LOCK_EN` undefined: no `lock` port; bursts always end at BURST transfers.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - the default N_REQ, W and BURST constants;
  - a `rr_pick` function (round-robin pick).
- Sub-module `muxn_w` is an N_REQ:1, W-bit combinational mux driven by `sel`. The arbiter registers its output into `y`.

## Test plan
- Reset mid-burst: assert `reset` during BUSY with `gnt`=0010 -> `gnt`, `y`, `y_valid` go to 0 at once. After release with `req`=0010, `gnt`=0010 is granted again starting from pointer 3.
- Single requester: `req`=0001, `d[0]`=2'b10, BURST=4 held -> `gnt`=0001 for 4 cycles, `y`=10 with `y_valid` for 4 cycles one cycle later, 1 idle cycle, then the next grant to 0.
- Round-robin: `req`=1111 held -> grant order 0,1,2,3,0. Each grant lasts 4 cycles with a 1-cycle bubble between grants; `y` carries each requester's distinct data (00,01,10,11).
- Early release: requester 2 granted, `req[2]` dropped after 2 transfers -> `y_valid` falls, `gnt`=0 at that edge, next grant goes to requester 3 if it is requesting.
- Lock (ARB_LOCK_EN): requester 1 holds `req` and `lock` -> 8 consecutive transfers with no bubble. Dropping `lock` limits the grant to BURST more transfers. Without the macro, the same stimulus gives exactly 4 transfers.
